// File: rtl/incr_share_arb.sv
// Round-robin arbiter sharing one registered increment stage among NREQ requesters.
// One operation in flight at a time; the result returns with its owner's ID.
module incr_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_quad,
    input  logic [NREQ*64-1:0]   req_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic                 resp_quad,
    output logic [63:0]          resp_data,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic           quad_q, quad_d;
    logic [63:0]    op_q, op_d;
    logic [63:0]    data_q, data_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    logic           found;
    logic [IDW-1:0] gnt;
    logic [IDW:0]   cand;

    // Scan from the highest offset down so the nearest valid requester wins.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && found) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        quad_d   = quad_q;
        op_d     = op_q;
        data_d   = data_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    op_d    = req_data[{gnt, 6'b0} +: 64];
                    quad_d  = req_quad[gnt];
                    id_d    = gnt;
                    state_d = EXEC;
                    if (gnt == IDW'(NREQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt + IDW'(1);
                    end
                end
            end
            EXEC: begin
                if (quad_q) begin
                    data_d = op_q + 64'd1;
                end else begin
                    data_d = {56'd0, op_q[7:0]} + 64'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            quad_q   <= 1'b0;
            op_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            quad_q   <= quad_d;
            op_q     <= op_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_id    = id_q;
    assign resp_quad  = quad_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;

endmodule

// File: doc/incr_share_arb.md
# incr_share_arb

Round-robin arbiter and sequencer that shares one increment datapath (8-bit narrow path with a 32-bit result, or 64-bit quad path) among `NREQ` requesters. It accepts one operation at a time through per-requester valid/ready handshakes and issues it to the registered increment stage. It returns the result with the winning requester's ID on a single response channel that honours backpressure. It sits between the requesting test logic and the increment stage, so that stage never sees overlapping operations.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `resp_id`; must equal clog2(`NREQ`).
- `clk`  in  1: sole clock, all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: request pending, bit i = requester i.
- `req_ready`  out  NREQ: grant/accept, at most one bit set.
- `req_quad`  in  NREQ: per requester, 1 = 64-bit quad op, 0 = 8-bit narrow op.
- `req_data`  in  NREQ*64: operands, requester i at [64*i+63:64*i].
- `resp_valid`  out  1: result available.
- `resp_ready`  in  1: consumer accepts result.
- `resp_id`  out  IDW: index of the requester that owns the result.
- `resp_quad`  out  1: op type of the result.
- `resp_data`  out  64: result.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping mod `NREQ`.
  - `req_ready[g]` is combinational from `req_valid` and the state, and is high only in IDLE.
  - Handshake on `req_valid[g] && req_ready[g]`: latch operand, op type and ID; `rr_ptr` <= (g+1) mod NREQ; go to EXEC.
  - No valid request: stay in IDLE; `rr_ptr` unchanged.
- EXEC:
  - Registered increment.
  - Narrow: `resp_data` <= {32'b0, 24'b0 + operand[7:0] + 32'd1}. Operand bits [63:8] are ignored. Result range is 0x1..0x100.
  - Quad: `resp_data` <= operand + 1 mod 2^64; no carry out.
  - Always go to RESP.
- RESP:
  - `resp_valid`=1. `resp_id`, `resp_quad` and `resp_data` stay stable until the handshake.
  - On `resp_valid && resp_ready`: go to IDLE.
  - `resp_ready` low: stay in RESP, hold all outputs.
- Only one operation is in flight; no request is accepted in EXEC or RESP.
- `req_data` and `req_quad` of non-granted requesters are don't-care. A requester may drop `req_valid` before it is granted without effect.
- Reset:
  - State = IDLE, `rr_ptr`=0.
  - `resp_valid`=0, `resp_id`=0, `resp_quad`=0, `resp_data`=0, `busy`=0, `req_ready`=0 during the reset cycle.
  - Reset in EXEC or RESP discards the in-flight op; no response is ever produced for it.

## Timing
- Accept at cycle T (handshake edge) gives EXEC at T+1 and `resp_valid` at T+2.
- With `resp_ready` held high: response handshake at T+2, IDLE at T+3, next accept at T+3 at the earliest. Peak throughput is one op per 3 cycles.
- Backpressure adds one cycle per cycle `resp_ready` is low. No data loss, no reordering.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,...,NREQ-1,0.
  - A new request arriving while in RESP is held off (`req_ready`=0) until IDLE.
- `busy` is registered and equals (state != IDLE).

## Test plan
- Narrow op: requester 0, `req_data`=0x12345678, `req_quad`=0. Requires `resp_valid` 2 cycles after accept with `resp_data`=0x79, `resp_id`=0, `resp_quad`=0.
- Quad op: requester 2, `req_data`=0x12345678_abcdef12, `req_quad`=1. Requires `resp_data`=0x12345678_abcdef13, `resp_id`=2.
- Wrap-around:
  - Narrow 0x...FF gives 0x100.
  - Quad 0xFFFFFFFF_FFFFFFFF gives 0x0.
  - Narrow 0xFFFFFFFF_FFFFFF00 gives 0x1 (upper bits ignored).
- Fairness: all 4 `req_valid` held high with `resp_ready`=1 for 15 ops. Requires `resp_id` sequence 0,1,2,3,0,1,...; at most one `req_ready` high at any time; accepts exactly 3 cycles apart.
- Backpressure: `resp_ready`=0 for 5 cycles after `resp_valid` rises, with other requesters valid. Requires `resp_*` stable, `req_ready`=0 throughout, and the next grant in the cycle after the handshake.
- Reset mid-op: assert `rst` in EXEC for one cycle. Requires no `resp_valid` for that op, `busy`=0 after reset, and the next grant going to requester 0 when all are valid.
